hex_byte_uart_sender: RTL
=========================

# hex_byte_uart_sender

- Transmit-side counterpart to the UART-receive/7-segment path: takes 8-bit values from fabric logic (switches, counters, debug taps) and sends each one to the host as human-readable ASCII hex text.
- Contains a small input FIFO, a frame sequencer, hex-to-ASCII conversion and its own 8N1 serializer.
- Drives the board's UART TX pin directly.

## Interface
Parameters:
- CLKS_PER_BIT, 217, clocks per UART bit (25 MHz / 115200); legal values ≥ 2.
- FIFO_DEPTH, 4, input byte FIFO entries; power of two, ≥ 2.

Ports:
- One clock; reset is asynchronous and active-low.
- i_Clk  input  1  system clock, all state on its rising edge.
- i_Rst_L  input  1  asynchronous active-low reset.
- i_DV  input  1  one-cycle strobe: i_Byte valid.
- i_Byte  input  8  byte to report.
- o_Ready  output  1  high when FIFO not full; combinational from FIFO count.
- o_Overflow  output  1  one-cycle pulse when i_DV is rejected because the FIFO is full.
- o_TX_Serial  output  1  UART line, idle high; registered.
- o_TX_Active  output  1  high while the sequencer is not in IDLE; registered.
- o_Frame_Done  output  1  one-cycle pulse at the end of the last stop bit of a frame.

## Operation
- **Reset values:** o_TX_Serial=1, o_TX_Active=0, o_Overflow=0, o_Frame_Done=0, FIFO empty (o_Ready=1), sequencer in IDLE.
- **Reset mid-frame:** the line returns high immediately, and the frame and all queued bytes are discarded.
- **Write:**
  - i_DV=1 with FIFO not full: i_Byte is pushed at that edge.
  - i_DV=1 with FIFO full: the byte is dropped and o_Overflow pulses on the next cycle.
  - A simultaneous pop in the same cycle does not make room for the write; a full FIFO rejects the write regardless.
- **Frame:** each popped byte B produces the character sequence:
  - ASCII(B[7:4]), then ASCII(B[3:0]), then 0x0D, then 0x0A.
  - Nibble mapping: 0–9 → 0x30–0x39; A–F → 0x41–0x46 (uppercase).
- **Character:** sent 8N1, LSB first. Each character is 10 bits: start 0, data[0..7], stop 1.
- **Sequencer states:** IDLE → START → DATA → STOP.
  - In STOP, if more characters remain in the frame, go to START with the next character and no idle gap.
  - After the final character's STOP:
    - FIFO not empty: pop and go to START directly (back-to-back frames, no gap).
    - FIFO empty: go to IDLE.
- **IDLE:** on FIFO not empty, pop one entry, latch the byte and frame character index 0, and enter START.
- **Counters:**
  - The bit-period counter counts 0..CLKS_PER_BIT-1, wrapping at the end of each bit.
  - The data-bit index counts 0..7.
  - The character index counts 0..3 (0..2 without CRLF, see Configuration).
- **FIFO:** read and write pointers each carry one extra wrap bit; full when the pointers differ only in the MSB.

## Timing
- **Latency:** if i_DV is sampled at edge E0 while the sequencer is IDLE and the FIFO is empty, then o_TX_Serial goes low and o_TX_Active goes high at E1.
- **Bit length:** every bit lasts exactly CLKS_PER_BIT cycles.
- **Frame length:** 40·CLKS_PER_BIT cycles with CRLF; 30·CLKS_PER_BIT without.
- **o_Frame_Done:** high for the single cycle after the final stop bit completes. This is the same edge at which the next start bit begins (FIFO not empty) or o_TX_Active falls (FIFO empty).
- **o_Ready:** updates the cycle after a push or pop.
- **Throughput:** sustained i_DV faster than one byte per frame time fills the FIFO and then overflows.

## Configuration
- `HEX_TX_CRLF_EN` defined: each frame is 4 characters, the two hex digits followed by 0x0D 0x0A.
- `HEX_TX_CRLF_EN` undefined: each frame is 3 characters, the two hex digits followed by a space (0x20). The character index wraps at 2.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4.
- **Single byte:** i_DV with 0x3C from reset → line decodes 0x33, 0x43, 0x0D, 0x0A. The start bit begins 1 cycle after the sampling edge. The frame is 160 cycles, and one o_Frame_Done pulse occurs at cycle 160.
- **Hex boundaries:** bytes 0x00, 0x9A, 0xFF → "00", "9A", "FF" (0x30 0x30, 0x39 0x41, 0x46 0x46), each followed by CRLF.
- **Burst and overflow:** 6 i_DV on consecutive cycles with 0x01..0x06 → bytes 0x01..0x05 are sent back-to-back with no idle bit between frames. o_Ready falls after the 5th write (one byte is popped immediately, four are queued). o_Overflow pulses once, for 0x06.
- **Reset mid-frame:** assert i_Rst_L=0 during the data bits of the second character → o_TX_Serial=1 and o_TX_Active=0 immediately. After release, the FIFO is empty and no further characters are sent.
- **Without `HEX_TX_CRLF_EN`:** byte 0xA5 → 0x41, 0x35, 0x20, in a 120-cycle frame.

Source files
------------

// File: rtl/hex_byte_uart_sender.sv
// hex_byte_uart_sender: queues bytes from fabric logic and reports each one on
// the UART TX line as ASCII hex text (8N1, LSB first).
// Optional feature macro: HEX_TX_CRLF_EN. When it is defined, each frame ends
// with CR LF. When it is undefined, each frame ends with a single space.
module hex_byte_uart_sender #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_DV,
  input  logic [7:0] i_Byte,
  output logic       o_Ready,
  output logic       o_Overflow,
  output logic       o_TX_Serial,
  output logic       o_TX_Active,
  output logic       o_Frame_Done
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

`ifdef HEX_TX_CRLF_EN
  localparam logic [1:0] LAST_CHAR = 2'd3;
`else
  localparam logic [1:0] LAST_CHAR = 2'd2;
`endif

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // FIFO storage and pointers; each pointer carries an extra wrap bit
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        full, empty, push, pop;
  logic [7:0]  head;
  logic        overflow_q;

  // Sequencer state
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    char_q, char_d;
  logic [7:0]    byte_q, byte_d;
  logic          tx_q, tx_d;
  logic          active_q, active_d;
  logic          done_q, done_d;
  logic          bit_end;
  logic [7:0]    cur_char;

  assign full  = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
  assign empty = (wr_ptr_q == rd_ptr_q);
  // A full FIFO rejects the write even if a pop happens in the same cycle
  assign push  = i_DV & ~full;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  assign o_Ready      = ~full;
  assign o_Overflow   = overflow_q;
  assign o_TX_Serial  = tx_q;
  assign o_TX_Active  = active_q;
  assign o_Frame_Done = done_q;

  function automatic logic [7:0] nib_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

  // Character selected by the frame index
  always_comb begin
    cur_char = 8'h20;
    unique case (char_q)
      2'd0: cur_char = nib_ascii(byte_q[7:4]);
      2'd1: cur_char = nib_ascii(byte_q[3:0]);
`ifdef HEX_TX_CRLF_EN
      2'd2: cur_char = 8'h0D;
      2'd3: cur_char = 8'h0A;
`else
      2'd2: cur_char = 8'h20;
      2'd3: cur_char = 8'h20;
`endif
      default: cur_char = 8'h20;
    endcase
  end

  // FIFO storage write, no reset needed on the data array
  always_ff @(posedge i_Clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= i_Byte;
  end

  // FIFO pointers and overflow pulse
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      overflow_q <= i_DV & full;
    end
  end

  assign bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));

  // Sequencer next state; line level and pulses are computed from the next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    char_d  = char_q;
    byte_d  = byte_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    pop     = 1'b0;

    if (state_q != StIdle) cnt_d = bit_end ? '0 : cnt_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          byte_d  = head;
          char_d  = 2'd0;
          cnt_d   = '0;
          tx_d    = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          bit_d   = 3'd0;
          tx_d    = cur_char[0];
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_char[bit_q + 3'd1];
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          if (char_q != LAST_CHAR) begin
            char_d  = char_q + 2'd1;
            tx_d    = 1'b0;
            state_d = StStart;
          end else begin
            done_d = 1'b1;
            if (!empty) begin
              // Back-to-back frame with no idle gap
              pop     = 1'b1;
              byte_d  = head;
              char_d  = 2'd0;
              tx_d    = 1'b0;
              state_d = StStart;
            end else begin
              tx_d    = 1'b1;
              state_d = StIdle;
            end
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = StIdle;
      end
    endcase

    active_d = (state_d != StIdle);
  end

  // Sequencer registers
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bit_q    <= 3'd0;
      char_q   <= 2'd0;
      byte_q   <= 8'h00;
      tx_q     <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      char_q   <= char_d;
      byte_q   <= byte_d;
      tx_q     <= tx_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

endmodule
